rll_key_loader: RTL
===================

// Module: rll_key_loader
// PURPOSE
//  Serial key-delivery unit for logic-locked netlists. Receives a locking key in CHUNK-bit
//  beats over a valid/ready stream and checks the parity of each beat. Keeps NUM_BANKS
//  complete keys and drives the active one onto the keyIn_* bus of the locked core.
//  Replaces tie-off keys with loadable, bank-switchable, atomically committed keys.
// PARAMETERS
//  KEY_WIDTH    32   total key bits; must be a multiple of CHUNK
//  CHUNK        8    bits per beat; BEATS = KEY_WIDTH/CHUNK, BEATS >= 2
//  NUM_BANKS    2    stored keys; BSEL_W = max(1,$clog2(NUM_BANKS))
//  DEFAULT_KEY  '0   reset contents of every bank
// PORTS
//  clk          in   1          single clock, rising edge
//  rst          in   1          asynchronous, active-high reset
//  load_start   in   1          pulse; begin loading bank bank_sel (honoured in IDLE/ERROR)
//  bank_switch  in   1          pulse; make bank_sel active without reloading (IDLE/ERROR only)
//  bank_sel     in   BSEL_W     target bank for load_start / bank_switch
//  chunk_valid  in   1          beat present
//  chunk_ready  out  1          loader accepts beat
//  chunk_data   in   CHUNK      key beat; first beat = most-significant chunk
//  chunk_par    in   1          even parity: chunk_par == ^chunk_data
//  key_out      out  KEY_WIDTH  active bank contents, registered
//  key_valid    out  1          a load has committed since reset (sticky)
//  active_bank  out  BSEL_W     index driving key_out
//  busy         out  1          state is LOAD or COMMIT
//  err          out  1          sticky in ERROR state
// BEHAVIOUR
//  Reset: all banks = DEFAULT_KEY, loaded[] = 0, active_bank = 0, key_out = DEFAULT_KEY,
//   key_valid = 0, err = 0, chunk_ready = 0, busy = 0, state IDLE. Reset mid-LOAD drops the shadow.
//  States: IDLE, LOAD, COMMIT, ERROR.
//  IDLE/ERROR:
//   - load_start with bank_sel < NUM_BANKS -> latch tgt, beat_cnt = 0, clear err, go LOAD.
//   - bank_switch with bank_sel valid and loaded[bank_sel] -> active_bank = bank_sel next edge.
//   - Out-of-range bank_sel, or bank_switch to an unloaded bank -> ERROR.
//   - load_start and bank_switch together -> load_start wins.
//  LOAD:
//   - chunk_ready = 1. A beat is accepted on chunk_valid & chunk_ready.
//   - Accepted beat: shadow = {shadow[KEY_WIDTH-CHUNK-1:0], chunk_data}; beat_cnt++.
//   - Parity mismatch -> ERROR; shadow discarded; banks and key_out untouched.
//   - Accepted beat with beat_cnt == BEATS-1 -> COMMIT.
//   - load_start and bank_switch are ignored. No timeout; an idle source holds LOAD.
//  COMMIT (one cycle): chunk_ready = 0; at the end edge bank[tgt] = shadow, loaded[tgt] = 1,
//   active_bank = tgt, key_valid = 1; then go IDLE.
//  Latency: last beat accepted at edge E -> key_out shows the new key after edge E+2.
//  key_out changes only at COMMIT or on a successful bank_switch. It never exposes a partial key.
//  err stays 1 until the next accepted load_start. chunk_ready is 0 outside LOAD.
// STRUCTURE
//  Package rll_key_pkg: state enum, BEATS/BSEL_W/CNT_W localparam helpers, parity function.
//  Sub-module rll_key_bank: NUM_BANKS x KEY_WIDTH register file with one write port and
//   a registered read of active_bank. The top holds the FSM, shadow register and beat counter.
// TESTING (KEY_WIDTH=32, CHUNK=8, NUM_BANKS=2)
//  1 Reset -> key_out=0x00000000, key_valid=0, chunk_ready=0, err=0, active_bank=0.
//  2 load_start bank 1, beats DE/0, AD/1, BE/0, EF/1 back-to-back -> key_out=0xDEADBEEF
//    two edges after the last beat, key_valid=1, active_bank=1.
//  3 Same load with 0-3 idle cycles between beats -> identical result, busy held throughout.
//  4 Load bank 0 with 0x12345678, bad parity on beat 3 -> err=1, chunk_ready=0,
//    key_out remains 0xDEADBEEF; bank_switch to bank 0 -> err stays (bank 0 not loaded).
//  5 Load 0x12345678 into bank 0, then bank_switch to 1 -> key_out=0xDEADBEEF one edge later;
//    load_start pulsed during LOAD -> ignored, beat count unaffected.
//  6 Assert rst after 2 beats of a load -> all outputs at reset values; next full load succeeds.

Source files
------------

// File: rtl/rll_key_pkg.sv
// Shared constants and helpers for the key loader: FSM encodings,
// derived-width helpers and the per-beat parity check.
package rll_key_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  // Widest beat the parity helper handles (zero-extension keeps parity intact)
  localparam int MAX_CHUNK = 64;

  function automatic int beats_f(input int key_width, input int chunk);
    return key_width / chunk;
  endfunction

  function automatic int bsel_w_f(input int num_banks);
    return (num_banks <= 2) ? 1 : $clog2(num_banks);
  endfunction

  function automatic int cnt_w_f(input int beats);
    return (beats <= 2) ? 1 : $clog2(beats);
  endfunction

  // Even parity: the sideband bit must equal the XOR of the data bits
  function automatic logic parity_ok(input logic [MAX_CHUNK-1:0] data, input logic par);
    return (^data) == par;
  endfunction

endpackage

// File: rtl/rll_key_bank.sv
// Key storage: NUM_BANKS x KEY_WIDTH registers, one write port,
// registered read of the selected (active) bank.
module rll_key_bank
  import rll_key_pkg::*;
#(
  parameter int                   KEY_WIDTH   = 32,
  parameter int                   NUM_BANKS   = 2,
  parameter int                   BSEL_W      = 1,
  parameter logic [KEY_WIDTH-1:0] DEFAULT_KEY = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [BSEL_W-1:0]    wr_idx,
  input  logic [KEY_WIDTH-1:0] wr_data,
  input  logic [BSEL_W-1:0]    rd_idx,
  output logic [KEY_WIDTH-1:0] rd_data
);

  logic [NUM_BANKS-1:0][KEY_WIDTH-1:0] mem;

  // Bank write: only the addressed bank takes the committed key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) mem[b] <= DEFAULT_KEY;
    end else if (wr_en) begin
      for (int b = 0; b < NUM_BANKS; b++)
        if (wr_idx == BSEL_W'(b)) mem[b] <= wr_data;
    end
  end

  // Registered read keeps key_out glitch-free toward the locked core
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= DEFAULT_KEY;
    else     rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/rll_key_loader.sv
// Serial key loader: collects CHUNK-bit parity-checked beats into a shadow
// register and commits a full key atomically into one of NUM_BANKS banks.
// The active bank drives key_out; banks can be switched without reloading.
module rll_key_loader
  import rll_key_pkg::*;
#(
  parameter int                   KEY_WIDTH   = 32,
  parameter int                   CHUNK       = 8,
  parameter int                   NUM_BANKS   = 2,
  parameter logic [KEY_WIDTH-1:0] DEFAULT_KEY = '0,
  parameter int                   BSEL_W      = bsel_w_f(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 bank_switch,
  input  logic [BSEL_W-1:0]    bank_sel,
  input  logic                 chunk_valid,
  output logic                 chunk_ready,
  input  logic [CHUNK-1:0]     chunk_data,
  input  logic                 chunk_par,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic [BSEL_W-1:0]    active_bank,
  output logic                 busy,
  output logic                 err
);

  localparam int BEATS = beats_f(KEY_WIDTH, CHUNK);
  localparam int CNT_W = cnt_w_f(BEATS);

  logic [1:0]           state;
  logic [BSEL_W-1:0]    tgt;
  logic [CNT_W-1:0]     beat_cnt;
  logic [KEY_WIDTH-1:0] shadow;
  logic [NUM_BANKS-1:0] loaded;
  logic                 sel_ok;
  logic                 beat_acc;
  logic                 beat_good;

  assign sel_ok      = int'(bank_sel) < NUM_BANKS;
  assign chunk_ready = (state == ST_LOAD);
  assign busy        = (state == ST_LOAD) || (state == ST_COMMIT);
  assign err         = (state == ST_ERROR);
  assign beat_acc    = chunk_valid && chunk_ready;
  assign beat_good   = parity_ok(MAX_CHUNK'(chunk_data), chunk_par);

  // Control FSM: command decode in IDLE/ERROR, beat collection, one-cycle commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      tgt         <= '0;
      beat_cnt    <= '0;
      shadow      <= '0;
      loaded      <= '0;
      active_bank <= '0;
      key_valid   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ERROR: begin
          // load_start takes priority over a simultaneous bank_switch
          if (load_start) begin
            if (sel_ok) begin
              tgt      <= bank_sel;
              beat_cnt <= '0;
              state    <= ST_LOAD;
            end else begin
              state <= ST_ERROR;
            end
          end else if (bank_switch) begin
            if (sel_ok && loaded[bank_sel]) active_bank <= bank_sel;
            else                            state       <= ST_ERROR;
          end
        end
        ST_LOAD: begin
          if (beat_acc) begin
            if (!beat_good) begin
              // Drop the partial key; banks and key_out are never touched
              shadow <= '0;
              state  <= ST_ERROR;
            end else begin
              shadow   <= {shadow[KEY_WIDTH-CHUNK-1:0], chunk_data};
              beat_cnt <= beat_cnt + 1'b1;
              if (beat_cnt == CNT_W'(BEATS - 1)) state <= ST_COMMIT;
            end
          end
        end
        ST_COMMIT: begin
          loaded[tgt] <= 1'b1;
          active_bank <= tgt;
          key_valid   <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rll_key_bank #(
    .KEY_WIDTH  (KEY_WIDTH),
    .NUM_BANKS  (NUM_BANKS),
    .BSEL_W     (BSEL_W),
    .DEFAULT_KEY(DEFAULT_KEY)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (state == ST_COMMIT),
    .wr_idx (tgt),
    .wr_data(shadow),
    .rd_idx (active_bank),
    .rd_data(key_out)
  );

endmodule
